romcode_arbiter: RTL and testbench
==================================

# romcode_arbiter

Two-requester arbiter/sequencer for the single-port romcode BRAM behind the SPI-flash emulator. It shares that port between the flash emulator's read path and a host loader port used to download and verify firmware images. It enforces a host lock while an image is loaded, bounds-checks addresses and tracks per-requester statistics. It sits between `spiflash` (romcode_* master side) and `bram`, and drives the BRAM pins directly.

## Interface
- `DEPTH_WORDS`, default 8192: BRAM size in 32-bit words; byte range 0 … 4·DEPTH_WORDS−1.
- `ERR_WORD`, default 32'hDEAD_BEEF: read data returned for out-of-range reads.
- `STARVE_MAX`, default 4: maximum consecutive flash grants while a host request waits.
- `ap_clk` in 1: single clock for all logic; `romcode_Clk_A` is driven from it.
- `ap_rst` in 1: synchronous, active-low reset.
- `fl_req` in 1: flash read request; held until granted.
- `fl_addr` in 32: flash byte address.
- `fl_gnt` out 1: flash request accepted this cycle.
- `fl_rvalid` out 1: flash read data valid.
- `fl_rdata` out 32: flash read data.
- `hs_req` in 1: host request; held until granted.
- `hs_we` in 4: byte write enables; 0 means read.
- `hs_addr` in 32: host byte address.
- `hs_wdata` in 32: host write data.
- `hs_gnt` out 1: host request accepted this cycle.
- `hs_rvalid` out 1: host read data valid.
- `hs_rdata` out 32: host read data.
- `hs_lock` in 1: when 1, the flash is never granted (image load in progress).
- `romcode_Addr_A` out 32: BRAM byte address; bits [1:0] always 0.
- `romcode_EN_A` out 1: BRAM enable.
- `romcode_WEN_A` out 4: BRAM byte write enables.
- `romcode_Din_A` out 32: BRAM write data.
- `romcode_Dout_A` in 32: BRAM read data.
- `romcode_Clk_A` out 1: equals `ap_clk`.
- `romcode_Rst_A` out 1: equals `~ap_rst` (active-high to BRAM).
- `err_sticky` out 1: set on any out-of-range access; cleared only by reset.
- `fl_cnt` out 16: granted flash requests, saturating.
- `hs_cnt` out 16: granted host requests, saturating.

## Operation
- **Arbitration.** The grant is combinational from the requests and registered state; at most one grant per cycle; `fl_gnt` and `hs_gnt` are never both 1.
- **Priority.** Flash has priority: `fl_gnt = fl_req & ~hs_lock & ~(hs_req & starve == STARVE_MAX)`. Otherwise `hs_gnt = hs_req`.
- **Starvation counter.** `starve` (3 bits) increments on each flash grant while `hs_req=1`. It clears on any host grant or when `hs_req=0`.
- **Issue stage.** A granted request is registered into the BRAM drive signals at the next edge:
  - `EN=1`.
  - `Addr = {addr[31:2],2'b00}`.
  - `WEN = hs_we` for host, `4'b0` for flash.
  - `Din = hs_wdata`.
  - A tag (owner, is_read, oob) is registered alongside.
- **Out-of-range (`addr[31:2] >= DEPTH_WORDS`).** `EN=0`, `WEN=0` in the issue stage, and `err_sticky` is set. The read still completes, with data `ERR_WORD`; the write is dropped.
- **Response stage.** Reads produce `*_rvalid` for one cycle to the tagged owner, with `*_rdata = oob ? ERR_WORD : romcode_Dout_A`. Writes produce no rvalid.
- **Idle defaults.** When there is no grant, the issue stage drives `EN=0`, `WEN=0`; `Addr` and `Din` hold their previous values.
- **Counters.** Each counter increments on its own grant and saturates at 16'hFFFF.
- **Host lock.** Raising `hs_lock` does not cancel flash reads already issued; they complete normally.

## Timing
- **Reset values.** On a reset edge with `ap_rst=0`, these are 0: all issue and response registers, `EN`, `WEN`, `Addr`, `Din`, `fl_rvalid`, `hs_rvalid`, `fl_rdata`, `hs_rdata`, `starve`, `err_sticky`, `fl_cnt`, `hs_cnt`.
- **Grants during reset.** Grants are forced to 0 while `ap_rst=0`.
- **Reset mid-operation.** In-flight reads are discarded; no rvalid is produced after reset.
- **Read latency.** Grant at edge N, BRAM EN at N+1, `*_rvalid` and `rdata` at N+2 (BRAM has 1-cycle read latency). Latency is fixed at 2 cycles from grant.
- **Throughput.** One access per cycle; back-to-back grants pipeline with no bubbles.
- **Read-after-write, same address.** A host read granted the cycle after a write to the same address returns the new data, because the BRAM write lands at N+1 and the read is issued at N+2.
- **Simultaneous requests.** When `fl_req` and `hs_req` are both asserted and `starve < STARVE_MAX`, flash wins. When `starve == STARVE_MAX`, host wins and `starve` clears to 0.

## Test plan
- **Basic flash read.** Preload word 0x10 = 32'h1234_5678; `fl_req` with `fl_addr=0x40` → `fl_gnt` the same cycle; `fl_rvalid=1`, `fl_rdata=32'h1234_5678` exactly 2 cycles later; `hs_rvalid` stays 0.
- **Host write, byte enables, readback.** Host writes 32'hAABB_CCDD to `0x80` with `hs_we=4'b1111`, then `hs_we=4'b0010` with data 32'h0000_EE00. Read of `0x80` in the next cycle → `hs_rdata=32'hAABB_EEDD`.
- **Contention and starvation.** Hold `fl_req` and `hs_req` continuously with `STARVE_MAX=4` → grants follow F,F,F,F,H,F,F,F,F,H…; `fl_cnt:hs_cnt` = 4:1 after 50 cycles (40:10).
- **Host lock.** `hs_lock=1` with `fl_req` held → `fl_gnt=0` for the whole lock. A flash read granted the cycle before lock still returns rvalid. After lock drops, the flash is granted in the next cycle.
- **Out-of-range access.** Read `addr = 4·DEPTH_WORDS` → `romcode_EN_A=0`; rvalid with 32'hDEAD_BEEF; `err_sticky=1`. A write to the same address leaves the BRAM unchanged.
- **Reset mid-read.** Grant a flash read, assert `ap_rst=0` at the next edge → no `fl_rvalid`; all outputs 0; counters 0; `err_sticky` 0.

Source files
------------

// File: rtl/romcode_arbiter.sv
// romcode_arbiter: shares the single-port romcode BRAM between the SPI-flash
// emulator read path and the host loader port. Flash has priority, bounded by
// a starvation counter; the host can lock the flash out during image loads.
// Each access is range-checked and owner-tagged through a two-stage pipeline.
module romcode_arbiter #(
  parameter int unsigned DEPTH_WORDS = 8192,
  parameter logic [31:0] ERR_WORD    = 32'hDEAD_BEEF,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic        ap_clk,
  input  logic        ap_rst,

  input  logic        fl_req,
  input  logic [31:0] fl_addr,
  output logic        fl_gnt,
  output logic        fl_rvalid,
  output logic [31:0] fl_rdata,

  input  logic        hs_req,
  input  logic [3:0]  hs_we,
  input  logic [31:0] hs_addr,
  input  logic [31:0] hs_wdata,
  output logic        hs_gnt,
  output logic        hs_rvalid,
  output logic [31:0] hs_rdata,
  input  logic        hs_lock,

  output logic [31:0] romcode_Addr_A,
  output logic        romcode_EN_A,
  output logic [3:0]  romcode_WEN_A,
  output logic [31:0] romcode_Din_A,
  input  logic [31:0] romcode_Dout_A,
  output logic        romcode_Clk_A,
  output logic        romcode_Rst_A,

  output logic        err_sticky,
  output logic [15:0] fl_cnt,
  output logic [15:0] hs_cnt
);

  typedef enum logic {
    OWN_FLASH = 1'b0,
    OWN_HOST  = 1'b1
  } owner_e;

  // Arbitration state
  logic [2:0]  starve;
  logic        starve_hit;
  logic        any_gnt;

  // Selected request
  logic [31:0] req_addr;
  logic [3:0]  req_we;
  logic        req_read;
  logic        req_oob;

  // Issue-stage tag
  logic        iss_valid;
  owner_e      iss_owner;
  logic        iss_read;
  logic        iss_oob;

  // Response-stage tag
  logic        resp_fl;
  logic        resp_hs;
  logic        resp_oob;
  logic [31:0] resp_word;

  assign romcode_Clk_A = ap_clk;
  assign romcode_Rst_A = ~ap_rst;

  // Grant decision: flash first unless locked out or the host has waited too long
  always_comb begin
    starve_hit = hs_req & (starve == 3'(STARVE_MAX));
    fl_gnt     = ap_rst & fl_req & ~hs_lock & ~starve_hit;
    hs_gnt     = ap_rst & hs_req & ~fl_gnt;
    any_gnt    = fl_gnt | hs_gnt;
  end

  // Request mux and range check for whichever requester was granted
  always_comb begin
    req_addr = hs_gnt ? hs_addr : fl_addr;
    req_we   = hs_gnt ? hs_we : '0;
    req_read = fl_gnt | (hs_gnt & (hs_we == '0));
    req_oob  = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
  end

  // Starvation counter: counts flash wins while the host is waiting
  always_ff @(posedge ap_clk) begin
    if (!ap_rst) begin
      starve <= '0;
    end else if (fl_gnt && hs_req) begin
      starve <= starve + 3'd1;
    end else if (hs_gnt || !hs_req) begin
      starve <= '0;
    end
  end

  // Issue stage: drive the BRAM pins and register the owner tag
  always_ff @(posedge ap_clk) begin
    if (!ap_rst) begin
      romcode_EN_A   <= 1'b0;
      romcode_WEN_A  <= '0;
      romcode_Addr_A <= '0;
      romcode_Din_A  <= '0;
      iss_valid      <= 1'b0;
      iss_owner      <= OWN_FLASH;
      iss_read       <= 1'b0;
      iss_oob        <= 1'b0;
    end else begin
      // Out-of-range accesses keep their tag so a read still answers,
      // but never reach the BRAM.
      romcode_EN_A  <= any_gnt & ~req_oob;
      romcode_WEN_A <= (any_gnt && !req_oob) ? req_we : '0;
      iss_valid     <= any_gnt;
      iss_owner     <= hs_gnt ? OWN_HOST : OWN_FLASH;
      iss_read      <= req_read;
      iss_oob       <= req_oob;
      if (any_gnt) begin
        romcode_Addr_A <= req_addr & 32'hFFFF_FFFC;
        romcode_Din_A  <= hs_wdata;
      end
    end
  end

  // Response stage: route the read return to its owner one cycle after issue
  always_ff @(posedge ap_clk) begin
    if (!ap_rst) begin
      resp_fl  <= 1'b0;
      resp_hs  <= 1'b0;
      resp_oob <= 1'b0;
    end else begin
      resp_fl  <= iss_valid & iss_read & (iss_owner == OWN_FLASH);
      resp_hs  <= iss_valid & iss_read & (iss_owner == OWN_HOST);
      resp_oob <= iss_oob;
    end
  end

  // BRAM data arrives in the response cycle; gate it to the owning port
  always_comb begin
    resp_word = resp_oob ? ERR_WORD : romcode_Dout_A;
    fl_rvalid = resp_fl;
    hs_rvalid = resp_hs;
    fl_rdata  = resp_fl ? resp_word : '0;
    hs_rdata  = resp_hs ? resp_word : '0;
  end

  // Sticky out-of-range flag, cleared only by reset
  always_ff @(posedge ap_clk) begin
    if (!ap_rst) begin
      err_sticky <= 1'b0;
    end else if (any_gnt && req_oob) begin
      err_sticky <= 1'b1;
    end
  end

  // Saturating per-requester grant counters
  always_ff @(posedge ap_clk) begin
    if (!ap_rst) begin
      fl_cnt <= '0;
      hs_cnt <= '0;
    end else begin
      if (fl_gnt && (fl_cnt != '1)) fl_cnt <= fl_cnt + 16'd1;
      if (hs_gnt && (hs_cnt != '1)) hs_cnt <= hs_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_romcode_arbiter.sv
// Testbench for romcode_arbiter: directed stimulus with a scoreboard queue of
// expected read returns, drained by an independent monitor.
module tb_romcode_arbiter;

  logic        ap_clk;
  logic        ap_rst;
  logic        fl_req;
  logic [31:0] fl_addr;
  logic        fl_gnt;
  logic        fl_rvalid;
  logic [31:0] fl_rdata;
  logic        hs_req;
  logic [3:0]  hs_we;
  logic [31:0] hs_addr;
  logic [31:0] hs_wdata;
  logic        hs_gnt;
  logic        hs_rvalid;
  logic [31:0] hs_rdata;
  logic        hs_lock;
  logic [31:0] romcode_Addr_A;
  logic        romcode_EN_A;
  logic [3:0]  romcode_WEN_A;
  logic [31:0] romcode_Din_A;
  logic [31:0] romcode_Dout_A;
  logic        romcode_Clk_A;
  logic        romcode_Rst_A;
  logic        err_sticky;
  logic [15:0] fl_cnt;
  logic [15:0] hs_cnt;

  romcode_arbiter #(
    .DEPTH_WORDS(8192),
    .ERR_WORD   (32'hDEAD_BEEF),
    .STARVE_MAX (4)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .fl_req        (fl_req),
    .fl_addr       (fl_addr),
    .fl_gnt        (fl_gnt),
    .fl_rvalid     (fl_rvalid),
    .fl_rdata      (fl_rdata),
    .hs_req        (hs_req),
    .hs_we         (hs_we),
    .hs_addr       (hs_addr),
    .hs_wdata      (hs_wdata),
    .hs_gnt        (hs_gnt),
    .hs_rvalid     (hs_rvalid),
    .hs_rdata      (hs_rdata),
    .hs_lock       (hs_lock),
    .romcode_Addr_A(romcode_Addr_A),
    .romcode_EN_A  (romcode_EN_A),
    .romcode_WEN_A (romcode_WEN_A),
    .romcode_Din_A (romcode_Din_A),
    .romcode_Dout_A(romcode_Dout_A),
    .romcode_Clk_A (romcode_Clk_A),
    .romcode_Rst_A (romcode_Rst_A),
    .err_sticky    (err_sticky),
    .fl_cnt        (fl_cnt),
    .hs_cnt        (hs_cnt)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // BRAM model: 1-cycle read latency, byte write enables; index wraps at 8K words
  logic [31:0] mem [0:8191];
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    mem[0]  = 32'hCAFE_F00D;
    mem[16] = 32'h1234_5678;
  end
  always @(posedge romcode_Clk_A) begin
    if (romcode_EN_A) begin
      for (int b = 0; b < 4; b++)
        if (romcode_WEN_A[b]) mem[romcode_Addr_A[14:2]][8*b +: 8] <= romcode_Din_A[8*b +: 8];
      romcode_Dout_A <= mem[romcode_Addr_A[14:2]];
    end
  end

  int cyc_cnt = 0;
  always @(posedge ap_clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Check grants this cycle and record the read return the bench expects
  task automatic grant(input logic ef, input logic eh, input logic rd,
                       input logic [31:0] d, input string nm);
    exp_t e;
    chk({nm, "_fl_gnt"}, 32'(fl_gnt), 32'(ef));
    chk({nm, "_hs_gnt"}, 32'(hs_gnt), 32'(eh));
    if (rd && (ef || eh)) begin
      e.owner = eh;
      e.data  = d;
      e.due   = cyc_cnt + 2;
      exp_q.push_back(e);
    end
  endtask

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  // Monitor: every rvalid pops one expectation and checks owner, data, latency
  always @(negedge ap_clk) begin
    if (fl_rvalid && hs_rvalid) begin
      n_cmp++;
      n_err++;
      $display("FAIL both_rvalid: got fl=1 hs=1 expected at most one");
    end else if (fl_rvalid || hs_rvalid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rvalid: got fl=%0b hs=%0b at cycle %0d expected none",
                 fl_rvalid, hs_rvalid, cyc_cnt);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rv_owner", 32'(hs_rvalid), 32'(e.owner));
        chk("rv_data", hs_rvalid ? hs_rdata : fl_rdata, e.data);
        chk("rv_cycle", 32'(cyc_cnt), 32'(e.due));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_en"},    32'(romcode_EN_A), 32'd0);
    chk({nm, "_wen"},   32'(romcode_WEN_A), 32'd0);
    chk({nm, "_addr"},  romcode_Addr_A, 32'd0);
    chk({nm, "_din"},   romcode_Din_A, 32'd0);
    chk({nm, "_flrv"},  32'(fl_rvalid), 32'd0);
    chk({nm, "_hsrv"},  32'(hs_rvalid), 32'd0);
    chk({nm, "_flrd"},  fl_rdata, 32'd0);
    chk({nm, "_hsrd"},  hs_rdata, 32'd0);
    chk({nm, "_err"},   32'(err_sticky), 32'd0);
    chk({nm, "_flcnt"}, 32'(fl_cnt), 32'd0);
    chk({nm, "_hscnt"}, 32'(hs_cnt), 32'd0);
    chk({nm, "_rsta"},  32'(romcode_Rst_A), 32'd1);
  endtask

  initial begin
    ap_rst = 1'b0; fl_req = 1'b1; fl_addr = 32'h40;
    hs_req = 1'b0; hs_we = 4'h0; hs_addr = 32'h0; hs_wdata = 32'h0; hs_lock = 1'b0;

    // Reset: grants forced low, all state cleared
    @(negedge ap_clk);
    grant(1'b0, 1'b0, 1'b0, 32'h0, "rst");
    tick; tick;
    @(negedge ap_clk);
    grant(1'b0, 1'b0, 1'b0, 32'h0, "rst2");
    chk_reset_outputs("rst");
    tick;
    fl_req = 1'b0; ap_rst = 1'b1;
    tick;

    // Basic flash read
    fl_req = 1'b1; fl_addr = 32'h40;
    @(negedge ap_clk); grant(1'b1, 1'b0, 1'b1, 32'h1234_5678, "fl_basic"); tick;
    fl_req = 1'b0;
    @(negedge ap_clk);
    chk("fl_basic_en", 32'(romcode_EN_A), 32'd1);
    chk("fl_basic_addr", romcode_Addr_A, 32'h40);
    chk("fl_basic_wen", 32'(romcode_WEN_A), 32'd0);
    tick; tick; tick;

    // Host full write, partial write, then readback
    hs_req = 1'b1; hs_we = 4'hF; hs_addr = 32'h80; hs_wdata = 32'hAABB_CCDD;
    @(negedge ap_clk); grant(1'b0, 1'b1, 1'b0, 32'h0, "hs_wr1"); tick;
    hs_we = 4'b0010; hs_wdata = 32'h0000_EE00;
    @(negedge ap_clk);
    chk("hs_wr1_en", 32'(romcode_EN_A), 32'd1);
    chk("hs_wr1_wen", 32'(romcode_WEN_A), 32'hF);
    chk("hs_wr1_din", romcode_Din_A, 32'hAABB_CCDD);
    grant(1'b0, 1'b1, 1'b0, 32'h0, "hs_wr2"); tick;
    hs_we = 4'h0;
    @(negedge ap_clk);
    chk("hs_wr2_wen", 32'(romcode_WEN_A), 32'b0010);
    grant(1'b0, 1'b1, 1'b1, 32'hAABB_EEDD, "hs_rd"); tick;
    hs_req = 1'b0;
    tick; tick;
    @(negedge ap_clk);
    chk("idle_en", 32'(romcode_EN_A), 32'd0);
    chk("idle_addr_hold", romcode_Addr_A, 32'h80);
    chk("idle_din_hold", romcode_Din_A, 32'h0000_EE00);
    tick;

    // Contention: F,F,F,F,H repeating
    fl_req = 1'b1; fl_addr = 32'h40; hs_req = 1'b1; hs_we = 4'h0; hs_addr = 32'h80;
    for (int i = 0; i < 50; i++) begin
      @(negedge ap_clk);
      if (i % 5 == 4) grant(1'b0, 1'b1, 1'b1, 32'hAABB_EEDD, "contend");
      else            grant(1'b1, 1'b0, 1'b1, 32'h1234_5678, "contend");
      tick;
    end
    fl_req = 1'b0; hs_req = 1'b0;
    @(negedge ap_clk);
    chk("contend_fl_cnt", 32'(fl_cnt), 32'd41);
    chk("contend_hs_cnt", 32'(hs_cnt), 32'd13);
    tick; tick; tick;

    // Host lock: earlier flash read completes, no flash grant while locked
    fl_req = 1'b1;
    @(negedge ap_clk); grant(1'b1, 1'b0, 1'b1, 32'h1234_5678, "pre_lock"); tick;
    hs_lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ap_clk); grant(1'b0, 1'b0, 1'b0, 32'h0, "locked"); tick;
    end
    hs_lock = 1'b0;
    @(negedge ap_clk); grant(1'b1, 1'b0, 1'b1, 32'h1234_5678, "unlock"); tick;
    fl_req = 1'b0;
    tick; tick; tick;

    // Out-of-range: read returns ERR_WORD, write is dropped
    hs_req = 1'b1; hs_we = 4'h0; hs_addr = 32'h8000;
    @(negedge ap_clk);
    chk("pre_oob_err", 32'(err_sticky), 32'd0);
    grant(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, "oob_rd"); tick;
    hs_we = 4'hF; hs_wdata = 32'h1111_1111;
    @(negedge ap_clk);
    chk("oob_rd_en", 32'(romcode_EN_A), 32'd0);
    chk("oob_err", 32'(err_sticky), 32'd1);
    grant(1'b0, 1'b1, 1'b0, 32'h0, "oob_wr"); tick;
    hs_we = 4'h0; hs_addr = 32'h0;
    @(negedge ap_clk);
    chk("oob_wr_en", 32'(romcode_EN_A), 32'd0);
    chk("oob_wr_wen", 32'(romcode_WEN_A), 32'd0);
    grant(1'b0, 1'b1, 1'b1, 32'hCAFE_F00D, "rd_word0"); tick;
    hs_req = 1'b0; fl_req = 1'b1; fl_addr = 32'hFFFF_FFFC;
    @(negedge ap_clk); grant(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, "fl_oob"); tick;
    fl_req = 1'b0;
    tick; tick;
    @(negedge ap_clk);
    chk("oob_fl_cnt", 32'(fl_cnt), 32'd44);
    chk("oob_hs_cnt", 32'(hs_cnt), 32'd16);
    tick;

    // Reset mid-read: the granted flash read must never return
    fl_req = 1'b1; fl_addr = 32'h40;
    @(negedge ap_clk); grant(1'b1, 1'b0, 1'b0, 32'h0, "pre_rst"); tick;
    fl_req = 1'b0; ap_rst = 1'b0;
    tick; tick;
    @(negedge ap_clk);
    chk_reset_outputs("midrst");
    tick;
    ap_rst = 1'b1;
    tick; tick; tick; tick;

    @(negedge ap_clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
